sdpram_rd_ctrl: RTL

SDPRAM_RD_CTRL -- requirements
Module: sdpram_rd_ctrl

---
 rtl/sdpram_rd_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/sdpram_rd_ctrl.sv
// sdpram_rd_ctrl: read-side controller for a simple dual-port RAM.
// Accepts read requests, issues the RAM read and tracks each read through a
// LATENCY-deep valid pipeline. Returning data is captured in a small response
// FIFO. Requests are only accepted while the pipeline plus FIFO have room, so
// the FIFO cannot overflow.
// Optional feature: define SDPRAM_RD_ERR_EN to flag out-of-range addresses.
// Such reads are still accepted but do not touch the RAM, and they return
// all-zero data with rd_rsp_err set.
module sdpram_rd_ctrl #(
  parameter int RAM_WIDTH  = 72,
  parameter int RAM_DEPTH  = 128,
  parameter int LATENCY    = 2,
  parameter int ADDR_WIDTH = $clog2(RAM_DEPTH),
  parameter int FIFO_DEPTH = LATENCY + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_done,
  input  logic                  rd_req_vld,
  input  logic [ADDR_WIDTH-1:0] rd_req_addr,
  output logic                  rd_req_rdy,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  output logic                  ram_rden,
  input  logic [RAM_WIDTH-1:0]  ram_doutb,
  output logic                  rd_rsp_vld,
  output logic [RAM_WIDTH-1:0]  rd_rsp_data,
  input  logic                  rd_rsp_rdy
`ifdef SDPRAM_RD_ERR_EN
  ,
  output logic                  rd_rsp_err
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OUT_W = $clog2(FIFO_DEPTH + LATENCY + 1);

  logic                 accept;
  logic                 push;
  logic                 pop;
  logic [LATENCY-1:0]   vld_pipe;
  logic [RAM_WIDTH-1:0] push_data;
  logic [RAM_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [OUT_W-1:0]     in_flight;
  logic [OUT_W-1:0]     outstanding;

  // The request address goes straight to the RAM; acceptance needs room
  // for the read in the pipeline and FIFO combined.
  assign ram_addrb   = rd_req_addr;
  assign outstanding = in_flight + OUT_W'(count);
  assign rd_req_rdy  = init_done & ~rst & (outstanding < OUT_W'(FIFO_DEPTH));
  assign accept      = rd_req_vld & rd_req_rdy;
  assign push        = vld_pipe[LATENCY-1];
  assign rd_rsp_vld  = ~rst & (count != CNT_W'(0));
  assign pop         = rd_rsp_vld & rd_rsp_rdy;
  assign rd_rsp_data = fifo_mem[rd_ptr];

`ifdef SDPRAM_RD_ERR_EN
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  logic               in_range;
  logic [LATENCY-1:0] err_pipe;
  logic               fifo_err [FIFO_DEPTH];

  assign in_range   = ({1'b0, rd_req_addr} < ADDR_LIMIT);
  assign ram_rden   = accept & in_range;
  assign push_data  = err_pipe[LATENCY-1] ? {RAM_WIDTH{1'b0}} : ram_doutb;
  assign rd_rsp_err = rd_rsp_vld & fifo_err[rd_ptr];

  // Carry the out-of-range flag alongside the read valid pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_pipe <= '0;
    end else begin
      err_pipe[0] <= accept & ~in_range;
      for (int i = 1; i < LATENCY; i++) begin
        err_pipe[i] <= err_pipe[i-1];
      end
    end
  end

  // Store the error flag next to its data word in the response FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_err[i] <= 1'b0;
      end
    end else if (push) begin
      fifo_err[wr_ptr] <= err_pipe[LATENCY-1];
    end else begin
      fifo_err[wr_ptr] <= fifo_err[wr_ptr];
    end
  end
`else
  assign ram_rden  = accept;
  assign push_data = ram_doutb;
`endif

  // Count reads still travelling through the RAM pipeline.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      in_flight = in_flight + OUT_W'(vld_pipe[i]);
    end
  end

  // Mark each accepted read so its data is captured LATENCY cycles later.
  // Reset clears the marks, so data still returning from the RAM is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= accept;
      for (int i = 1; i < LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
      end
    end
  end

  // Response storage; cleared on reset so the head reads as zero until the
  // first word arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else if (push) begin
      fifo_mem[wr_ptr] <= push_data;
    end else begin
      fifo_mem[wr_ptr] <= fifo_mem[wr_ptr];
    end
  end

  // FIFO pointers and occupancy. Pointers wrap at FIFO_DEPTH, which need not
  // be a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? PTR_W'(0) : wr_ptr + PTR_W'(1);
      end else begin
        wr_ptr <= wr_ptr;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? PTR_W'(0) : rd_ptr + PTR_W'(1);
      end else begin
        rd_ptr <= rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
